alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle unsigned 32x32→64 multiply sequencer that reuses the shared combinational ALU as its adder. It runs a shift-and-add loop, driving the ALU operand and control lines once per cycle and capturing the ALU sum and carry. It sits between the control unit, which issues a start, and the ALU input/output buses. The result is available 33 cycles after start.

## Interface
- No parameters. Width is fixed at 32 to match the ALU buses.
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a multiply; sampled only in IDLE or DONE
- op_a  input  32  multiplicand; sampled on the accepting edge
- op_b  input  32  multiplier; sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE; product is valid
- product_hi  output  32  upper product word; held until the next accepted start
- product_lo  output  32  lower product word; held until the next accepted start
- alu_ina  output  32  to ALU ina
- alu_inb  output  32  to ALU inb
- alu_aluc  output  4  to ALU aluc
- alu_cin  output  1  to ALU cin; always 0
- alu_out  input  32  from ALU out
- alu_cout  input  1  from ALU cout

## Operation
- Internal registers:
  - A: 32-bit latched multiplicand.
  - P_hi, P_lo: 32 bits each; product_hi = P_hi, product_lo = P_lo.
  - cnt: 5-bit iteration counter.
  - state: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, alu_aluc=4'b1000 (ALU constant zero), alu_ina=alu_inb=0.
  - start=1: A←op_a, P_hi←0, P_lo←op_b, cnt←0, go to RUN.
- RUN: busy=1, alu_aluc=4'b0100 (ADD), alu_ina=P_hi, alu_inb = P_lo[0] ? A : 32'h0.
  - Each edge: {P_hi,P_lo} ← {alu_cout, alu_out, P_lo[31:1]}, i.e. the 65-bit sum shifted right by 1. cnt←cnt+1.
  - If P_lo[0]=0, the ALU adds zero and returns cout=0, so the step degenerates to a plain shift. No special case.
  - Edge with cnt==31: go to DONE.
  - start is ignored in RUN. No abort exists; only reset stops an operation.
- DONE: done=1, busy=0, ALU lines as in IDLE.
  - start=1: accepted exactly as in IDLE and goes to RUN (back-to-back operation). Otherwise go to IDLE.
- The ALU flags (negative, zero, overflow) are not used.
- Arithmetic is unsigned only. The carry is taken from alu_cout, never recomputed locally.

## Timing
- Reset (asynchronous, any time, including mid-RUN):
  - state=IDLE; busy=0, done=0, product_hi=product_lo=0, cnt=0, A=0.
  - ALU lines go to IDLE values immediately.
  - An interrupted operation is discarded; no done pulse is issued for it.
- Latency: start sampled high at edge E0 → RUN during E0..E32 (32 iterations on edges E1..E32) → done=1 in the cycle after E32.
  - Start edge to done: 33 cycles.
  - Throughput with back-to-back starts: one result per 33 cycles.
- ALU path: outputs are combinational from registers. The ALU result is captured at the end of the same cycle, giving a single-cycle path through the ALU.
- product_hi/lo are not valid during RUN, where they show partial values. They are valid from the DONE cycle until the next accepted start.
- Counter wrap: cnt wraps 31→0 on the last edge; the state change takes precedence over the wrap.
- Simultaneous reset and start: reset wins.

## Test plan
- op_a=3, op_b=5, start 1 cycle → done on cycle 33 with product_hi=0, product_lo=15; busy high for exactly 32 cycles.
- op_a=op_b=32'hFFFFFFFF → product_hi=32'hFFFFFFFE, product_lo=32'h00000001. Exercises alu_cout on every step.
- op_a=0, op_b=32'h12345678 → product=0. Also op_a=32'h12345678, op_b=0 → product=0. alu_inb=0 on every RUN cycle of the second case.
- op_a=7, op_b=9 → 63. Then pulse start with op_a=2, op_b=2 mid-RUN → ignored, result still 63. Then start in the DONE cycle with 2×2 → busy next cycle, done 33 cycles later with 4.
- Assert reset at RUN cycle 10 of 32'h10000×32'h10000 → IDLE, product=0, no done. A new start of 32'h10000×32'h10000 → product_hi=1, product_lo=0.
- Random unsigned pairs (≥1000) against a 64-bit reference model. Check every done pulse and check that alu_cin stays 0 throughout.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned 32x32->64 shift-and-add multiplier that borrows the
// shared combinational ALU as its adder, one iteration per clock.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product_hi,
    output logic [31:0] product_lo,
    output logic [31:0] alu_ina,
    output logic [31:0] alu_inb,
    output logic [3:0]  alu_aluc,
    output logic        alu_cin,
    input  logic [31:0] alu_out,
    input  logic        alu_cout
);

    localparam logic [3:0] ALUC_ZERO = 4'b1000;
    localparam logic [3:0] ALUC_ADD  = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        accept;

    // A start is only honoured when no multiply is in flight.
    assign accept = start && (state_q != S_RUN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: 32 iterations in RUN, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE:  state_d = accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: status flags and the ALU operand/control lines.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        alu_aluc = ALUC_ZERO;
        alu_ina  = 32'h0;
        alu_inb  = 32'h0;
        alu_cin  = 1'b0;
        case (state_q)
            S_RUN: begin
                busy     = 1'b1;
                alu_aluc = ALUC_ADD;
                alu_ina  = phi_q;
                alu_inb  = plo_q[0] ? a_q : 32'h0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: load on accept, shift the 65-bit ALU sum in RUN.
    always_comb begin
        a_d   = a_q;
        phi_d = phi_q;
        plo_d = plo_q;
        cnt_d = cnt_q;
        if (accept) begin
            a_d   = op_a;
            phi_d = 32'h0;
            plo_d = op_b;
            cnt_d = 5'd0;
        end else if (state_q == S_RUN) begin
            // A zero multiplier bit makes the ALU add zero, so this is a plain shift.
            {phi_d, plo_d} = {alu_cout, alu_out, plo_q[31:1]};
            cnt_d          = cnt_q + 5'd1;
        end
    end

    // Datapath registers; reset discards any operation in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= 32'h0;
            phi_q <= 32'h0;
            plo_q <= 32'h0;
            cnt_q <= 5'd0;
        end else begin
            a_q   <= a_d;
            phi_q <= phi_d;
            plo_q <= plo_d;
            cnt_q <= cnt_d;
        end
    end

    assign product_hi = phi_q;
    assign product_lo = plo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: behavioural ALU plus a product scoreboard.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        busy, done;
    logic [31:0] product_hi, product_lo;
    logic [31:0] alu_ina, alu_inb, alu_out;
    logic [3:0]  alu_aluc;
    logic        alu_cin, alu_cout;

    int errors = 0;
    int checks = 0;
    int cin_bad = 0;
    int dones_seen = 0;
    logic [63:0] exp_q[$];

    alu_mul_seq dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product_hi(product_hi), .product_lo(product_lo),
        .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_aluc(alu_aluc), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Shared ALU model: ADD and constant-zero are the only codes used.
    logic [32:0] alu_sum;
    always_comb begin
        alu_sum = 33'h0;
        if (alu_aluc == 4'b0100)
            alu_sum = {1'b0, alu_ina} + {1'b0, alu_inb} + {32'h0, alu_cin};
        alu_out  = alu_sum[31:0];
        alu_cout = alu_sum[32];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (alu_cin !== 1'b0) cin_bad++;
        if (!reset && done) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                check("product", {product_hi, product_lo}, exp_q.pop_front());
                check("busy_in_done", {63'd0, busy}, 64'd0);
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit push);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        if (push) exp_q.push_back({32'h0, a} * {32'h0, b});
    endtask

    // Waits (bounded) for done; lat counts negedges from the call.
    task automatic wait_done(output int lat, output int busy_n, output int inb_nz);
        lat = 0; busy_n = 0; inb_nz = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_n++;
            if (busy && alu_inb != 32'h0) inb_nz++;
            if (done) break;
            if (lat > 40) begin
                check("timeout", 64'(lat), 64'd33);
                break;
            end
        end
    endtask

    int lat, bn, nz, d0;
    logic [31:0] ra, rb;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", {product_hi, product_lo}, 64'd0);
        check("rst_aluc", {60'd0, alu_aluc}, 64'h8);
        check("rst_ina_inb", {alu_ina, alu_inb}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 3 x 5: latency and busy width
        launch(32'd3, 32'd5, 1);
        wait_done(lat, bn, nz);
        check("lat_3x5", 64'(lat), 64'd33);
        check("busy_cycles_3x5", 64'(bn), 64'd32);
        @(negedge clk);
        check("hold_after_done", {product_hi, product_lo}, 64'd15);
        check("done_one_pulse", {63'd0, done}, 64'd0);

        // all ones: carry on every step
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        wait_done(lat, bn, nz);
        check("lat_ff", 64'(lat), 64'd33);

        // zero operands
        @(negedge clk);
        launch(32'h0, 32'h12345678, 1);
        wait_done(lat, bn, nz);
        @(negedge clk);
        launch(32'h12345678, 32'h0, 1);
        wait_done(lat, bn, nz);
        check("inb_zero_cycles", 64'(nz), 64'd0);

        // start mid-RUN ignored, then back-to-back start in DONE
        @(negedge clk);
        launch(32'd7, 32'd9, 1);
        repeat (5) begin @(negedge clk); start = 1'b0; end
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn, nz);
        check("lat_with_ignored_start", 64'(lat + 6), 64'd33);
        launch(32'd2, 32'd2, 1);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_b2b", {63'd0, busy}, 64'd1);
        wait_done(lat, bn, nz);
        check("lat_b2b", 64'(lat + 1), 64'd33);

        // reset in the middle of a run
        @(negedge clk);
        launch(32'h10000, 32'h10000, 0);
        repeat (10) begin @(negedge clk); start = 1'b0; end
        d0 = dones_seen;
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_product", {product_hi, product_lo}, 64'd0);
        check("midrst_aluc", {60'd0, alu_aluc}, 64'h8);
        check("midrst_ina_inb", {alu_ina, alu_inb}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_done", 64'(dones_seen), 64'(d0));
        launch(32'h10000, 32'h10000, 1);
        wait_done(lat, bn, nz);
        check("lat_after_rst", 64'(lat), 64'd33);

        // random pairs, issued back-to-back from each DONE cycle
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            if (i == 0) ra = 32'hFFFFFFFF;
            if (i == 1) rb = 32'h80000001;
            launch(ra, rb, 1);
            wait_done(lat, bn, nz);
        end
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("alu_cin_nonzero_cycles", 64'(cin_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
